// File: rtl/frame_write_controller.sv
// Capture-domain write sequencer: aligns camera pixels to start-of-frame and
// drives linear addresses, data and enable into the frame buffer write port.
module frame_write_controller #(
   parameter int WIDTH      = 12,
   parameter int DEPTH      = 76800,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  enable_i,
   input  logic                  single_shot_i,
   input  logic                  clear_errors_i,
   input  logic                  sof_i,
   input  logic                  pixel_valid_i,
   input  logic [WIDTH-1:0]      pixel_data_i,
   output logic                  write_en_o,
   output logic [ADDR_WIDTH-1:0] write_address_o,
   output logic [WIDTH-1:0]      write_data_o,
   output logic                  busy_o,
   output logic                  frame_done_o,
   output logic [15:0]           frame_count_o,
   output logic                  error_short_o,
   output logic                  error_long_o
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_SOF = 3'd1,
      CAPTURE  = 3'd2,
      DONE     = 3'd3,
      HALT     = 3'd4
   } state_e;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0]      data_q, data_d;
   logic                  done_q, done_d;
   logic [15:0]           count_q, count_d;
   logic                  err_short_q, err_short_d;
   logic                  err_long_q, err_long_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         done_q      <= 1'b0;
         count_q     <= '0;
         err_short_q <= 1'b0;
         err_long_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         done_q      <= done_d;
         count_q     <= count_d;
         err_short_q <= err_short_d;
         err_long_q  <= err_long_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = 1'b0;
      addr_d      = addr_q;
      data_d      = data_q;
      done_d      = 1'b0;
      count_d     = count_q;
      // Clear is applied first so a coincident error event below wins.
      err_short_d = err_short_q & ~clear_errors_i;
      err_long_d  = err_long_q & ~clear_errors_i;

      if (!enable_i) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: state_d = WAIT_SOF;
            WAIT_SOF, DONE: begin
               if (sof_i) begin
                  state_d = CAPTURE;
                  cnt_d   = '0;
                  if (pixel_valid_i) begin
                     we_d   = 1'b1;
                     addr_d = '0;
                     data_d = pixel_data_i;
                     cnt_d  = ADDR_WIDTH'(1);
                  end
               end else if (pixel_valid_i && state_q == DONE) begin
                  err_long_d = 1'b1;
               end
            end
            CAPTURE: begin
               if (pixel_valid_i && cnt_q == LAST_ADDR) begin
                  // Last pixel wins over a coincident sof_i, which then only
                  // opens the next frame when capture continues.
                  we_d    = 1'b1;
                  addr_d  = cnt_q;
                  data_d  = pixel_data_i;
                  done_d  = 1'b1;
                  count_d = count_q + 16'd1;
                  cnt_d   = '0;
                  if (single_shot_i) state_d = HALT;
                  else if (sof_i)    state_d = CAPTURE;
                  else               state_d = DONE;
               end else if (sof_i) begin
                  err_short_d = 1'b1;
                  cnt_d       = '0;
                  if (pixel_valid_i) begin
                     we_d   = 1'b1;
                     addr_d = '0;
                     data_d = pixel_data_i;
                     cnt_d  = ADDR_WIDTH'(1);
                  end
               end else if (pixel_valid_i) begin
                  we_d   = 1'b1;
                  addr_d = cnt_q;
                  data_d = pixel_data_i;
                  cnt_d  = cnt_q + ADDR_WIDTH'(1);
               end
            end
            HALT: state_d = HALT;
            default: state_d = IDLE;
         endcase
      end
   end

   assign write_en_o      = we_q;
   assign write_address_o = addr_q;
   assign write_data_o    = data_q;
   assign busy_o          = (state_q == CAPTURE);
   assign frame_done_o    = done_q;
   assign frame_count_o   = count_q;
   assign error_short_o   = err_short_q;
   assign error_long_o    = err_long_q;

endmodule

// File: tb/tb_frame_write_controller.sv
// Directed bench for frame_write_controller with DEPTH=16: a cycle table for
// the basic frame plus hand-written sequences for multi-cycle corner cases.
module tb_frame_write_controller;

   localparam int WIDTH = 12;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic             clk = 1'b0;
   logic             rst_ni = 1'b0;
   logic             enable_i = 1'b0;
   logic             single_shot_i = 1'b0;
   logic             clear_errors_i = 1'b0;
   logic             sof_i = 1'b0;
   logic             pixel_valid_i = 1'b0;
   logic [WIDTH-1:0] pixel_data_i = '0;
   logic             write_en_o;
   logic [AW-1:0]    write_address_o;
   logic [WIDTH-1:0] write_data_o;
   logic             busy_o;
   logic             frame_done_o;
   logic [15:0]      frame_count_o;
   logic             error_short_o;
   logic             error_long_o;

   frame_write_controller #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable_i),
      .single_shot_i(single_shot_i), .clear_errors_i(clear_errors_i),
      .sof_i(sof_i), .pixel_valid_i(pixel_valid_i), .pixel_data_i(pixel_data_i),
      .write_en_o(write_en_o), .write_address_o(write_address_o),
      .write_data_o(write_data_o), .busy_o(busy_o), .frame_done_o(frame_done_o),
      .frame_count_o(frame_count_o), .error_short_o(error_short_o),
      .error_long_o(error_long_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   logic [AW+WIDTH-1:0] got_q[$];
   logic [AW+WIDTH-1:0] exp_q[$];

   // Monitor: record every RAM write and every frame_done pulse.
   always @(negedge clk) begin
      if (rst_ni && write_en_o) got_q.push_back({write_address_o, write_data_o});
      if (rst_ni && frame_done_o) done_cnt++;
   end

   typedef struct {
      logic             sof;
      logic             pv;
      logic [WIDTH-1:0] data;
      logic             we;
      logic [AW-1:0]    addr;
      logic [WIDTH-1:0] wdata;
      logic             done;
      logic [15:0]      count;
      logic             busy;
   } vec_t;
   vec_t vecs[18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic sof, input logic pv, input logic [WIDTH-1:0] d);
      sof_i = sof;
      pixel_valid_i = pv;
      pixel_data_i = d;
      @(posedge clk);
      #1;
      sof_i = 1'b0;
      pixel_valid_i = 1'b0;
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      enable_i = 1'b0;
      single_shot_i = 1'b0;
      clear_errors_i = 1'b0;
      sof_i = 1'b0;
      pixel_valid_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      got_q.delete();
      exp_q.delete();
      done_cnt = 0;
      rst_ni = 1'b1;
   endtask

   task automatic push_frame(input int first_data);
      for (int i = 0; i < DEPTH; i++)
         exp_q.push_back({AW'(i), WIDTH'(first_data + i)});
   endtask

   task automatic check_writes(input string name);
      @(negedge clk);
      #1;
      chk({name, "_nwrites"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         chk({name, "_write"}, got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      // Basic frame table: enable, then sof with first pixel, then 15 more.
      vecs[0] = '{sof: 1'b0, pv: 1'b0, data: '0, we: 1'b0, addr: '0, wdata: '0,
                  done: 1'b0, count: 16'd0, busy: 1'b0};
      for (int i = 1; i <= 16; i++) begin
         vecs[i].sof   = (i == 1);
         vecs[i].pv    = 1'b1;
         vecs[i].data  = WIDTH'(i);
         vecs[i].we    = 1'b1;
         vecs[i].addr  = AW'(i - 1);
         vecs[i].wdata = WIDTH'(i);
         vecs[i].done  = (i == 16);
         vecs[i].count = (i == 16) ? 16'd1 : 16'd0;
         vecs[i].busy  = (i != 16);
      end
      vecs[17] = '{sof: 1'b0, pv: 1'b0, data: '0, we: 1'b0, addr: 4'd15, wdata: '0,
                   done: 1'b0, count: 16'd1, busy: 1'b0};

      do_reset();
      chk("reset_we", write_en_o, 0);
      chk("reset_addr", write_address_o, 0);
      chk("reset_busy", busy_o, 0);
      chk("reset_count", frame_count_o, 0);
      chk("reset_errors", {error_short_o, error_long_o}, 0);

      enable_i = 1'b1;
      for (int i = 0; i < 18; i++) begin
         cyc(vecs[i].sof, vecs[i].pv, vecs[i].data);
         chk("tbl_we", write_en_o, vecs[i].we);
         chk("tbl_addr", write_address_o, vecs[i].addr);
         if (vecs[i].we) chk("tbl_data", write_data_o, vecs[i].wdata);
         chk("tbl_done", frame_done_o, vecs[i].done);
         chk("tbl_count", frame_count_o, vecs[i].count);
         chk("tbl_busy", busy_o, vecs[i].busy);
      end
      push_frame(1);
      check_writes("tbl");

      // Continuous capture, three frames, pixel_valid every other cycle.
      do_reset();
      enable_i = 1'b1;
      cyc(0, 0, 0);
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < DEPTH; i++) begin
            cyc(i == 0, 1, WIDTH'(f * 16 + i + 1));
            cyc(0, 0, 0);
         end
         push_frame(f * 16 + 1);
      end
      check_writes("cont");
      chk("cont_count", frame_count_o, 3);
      chk("cont_done_pulses", done_cnt, 3);
      chk("cont_errors", {error_short_o, error_long_o}, 0);

      // Short frame: sof after 10 pixels restarts at address 0.
      do_reset();
      enable_i = 1'b1;
      cyc(0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         cyc(i == 0, 1, WIDTH'(12'h100 + i));
         exp_q.push_back({AW'(i), WIDTH'(12'h100 + i)});
      end
      for (int i = 0; i < DEPTH; i++) cyc(i == 0, 1, WIDTH'(12'h200 + i));
      push_frame(12'h200);
      check_writes("short");
      chk("short_err", error_short_o, 1);
      chk("short_long_err", error_long_o, 0);
      chk("short_done_pulses", done_cnt, 1);
      chk("short_count", frame_count_o, 1);

      // Long frame: extra pixels after completion, then clear.
      do_reset();
      enable_i = 1'b1;
      cyc(0, 0, 0);
      for (int i = 0; i < DEPTH; i++) cyc(i == 0, 1, WIDTH'(12'h300 + i));
      push_frame(12'h300);
      cyc(0, 1, 12'hAAA);
      cyc(0, 1, 12'hBBB);
      check_writes("long");
      chk("long_err", error_long_o, 1);
      chk("long_short_err", error_short_o, 0);
      clear_errors_i = 1'b1;
      cyc(0, 1, 12'hCCC);
      chk("long_set_wins", error_long_o, 1);
      cyc(0, 0, 0);
      clear_errors_i = 1'b0;
      chk("long_cleared", error_long_o, 0);

      // Single shot: halt after one frame, re-arm by toggling enable.
      do_reset();
      enable_i = 1'b1;
      single_shot_i = 1'b1;
      cyc(0, 0, 0);
      for (int i = 0; i < DEPTH; i++) cyc(i == 0, 1, WIDTH'(12'h400 + i));
      push_frame(12'h400);
      chk("ss_busy", busy_o, 0);
      for (int i = 0; i < 5; i++) cyc(i == 0, 1, WIDTH'(12'h500 + i));
      check_writes("ss_halt");
      chk("ss_no_long_err", error_long_o, 0);
      chk("ss_count", frame_count_o, 1);
      enable_i = 1'b0;
      single_shot_i = 1'b0;
      cyc(0, 0, 0);
      enable_i = 1'b1;
      cyc(0, 0, 0);
      for (int i = 0; i < DEPTH; i++) cyc(i == 0, 1, WIDTH'(12'h600 + i));
      push_frame(12'h600);
      check_writes("ss_rearm");
      chk("ss_count2", frame_count_o, 2);

      // Last pixel coinciding with sof: frame completes and next one starts.
      do_reset();
      enable_i = 1'b1;
      cyc(0, 0, 0);
      for (int i = 0; i < DEPTH; i++) cyc(i == 0 || i == DEPTH - 1, 1, WIDTH'(12'h700 + i));
      chk("coinc_busy", busy_o, 1);
      for (int i = 0; i < DEPTH; i++) cyc(0, 1, WIDTH'(12'h800 + i));
      push_frame(12'h700);
      push_frame(12'h800);
      check_writes("coinc");
      chk("coinc_done_pulses", done_cnt, 2);
      chk("coinc_short_err", error_short_o, 0);

      // Abort by disabling after 7 pixels, restart, then async reset.
      do_reset();
      enable_i = 1'b1;
      cyc(0, 0, 0);
      for (int i = 0; i < 7; i++) begin
         cyc(i == 0, 1, WIDTH'(12'h900 + i));
         exp_q.push_back({AW'(i), WIDTH'(12'h900 + i)});
      end
      enable_i = 1'b0;
      cyc(0, 1, 12'hEEE);
      chk("abort_we", write_en_o, 0);
      chk("abort_addr_hold", write_address_o, 6);
      cyc(0, 1, 12'hEEE);
      check_writes("abort");
      chk("abort_done_pulses", done_cnt, 0);
      chk("abort_count", frame_count_o, 0);
      enable_i = 1'b1;
      cyc(0, 0, 0);
      cyc(1, 1, 12'hA00);
      chk("restart_we", write_en_o, 1);
      chk("restart_addr", write_address_o, 0);
      cyc(0, 1, 12'hA01);
      cyc(0, 1, 12'hA02);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("async_rst_we", write_en_o, 0);
      chk("async_rst_addr", write_address_o, 0);
      chk("async_rst_data", write_data_o, 0);
      chk("async_rst_busy", busy_o, 0);
      chk("async_rst_misc", {frame_done_o, frame_count_o, error_short_o, error_long_o}, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
